// File: rtl/gate_cmd_apply_pkg.sv
// Shared command encodings, leg states and byte classification for the
// module-side gate command link.
package gate_cmd_apply_pkg;

  localparam int         CMD_FLAG_BIT = 7;
  localparam logic [7:0] CMD_DISABLE  = 8'h80;
  localparam logic [7:0] CMD_ENABLE   = 8'h81;

  typedef enum logic [1:0] {
    LEG_OFF   = 2'd0,
    LEG_DEAD  = 2'd1,
    LEG_ON_HI = 2'd2,
    LEG_ON_LO = 2'd3
  } leg_state_e;

  typedef enum logic [2:0] {
    BYTE_NONE,
    BYTE_PATTERN,
    BYTE_DISABLE,
    BYTE_ENABLE,
    BYTE_REJECT
  } byte_kind_e;

  function automatic byte_kind_e classify_byte(input logic       done,
                                               input logic       perr,
                                               input logic [7:0] data);
    if (!done)                   return BYTE_NONE;
    if (perr)                    return BYTE_REJECT;
    if (!data[CMD_FLAG_BIT])     return BYTE_PATTERN;
    if (data == CMD_DISABLE)     return BYTE_DISABLE;
    if (data == CMD_ENABLE)      return BYTE_ENABLE;
    return BYTE_REJECT;
  endfunction

endpackage

// File: rtl/gate_cmd_apply_if.sv
// Byte stream from the per-module uart_rx into the gate command decoder.
interface gate_cmd_apply_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;

  modport master (output rx_data, rx_done, parity_error);
  modport slave  (input  rx_data, rx_done, parity_error);
endinterface

// File: rtl/gate_cmd_apply_dead_time_leg.sv
// One half-bridge leg: never drives both gates, and holds both off for
// DEAD_CYCLES clocks before turning either gate on.
module dead_time_leg
  import gate_cmd_apply_pkg::*;
#(
  parameter int DEAD_CYCLES = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic target,
  output logic hi,
  output logic lo
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);

  leg_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          tgt_q;
  logic          hi_q;
  logic          lo_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LEG_OFF;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else if (!en) begin
      state_q <= LEG_OFF;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      case (state_q)
        LEG_OFF: begin
          state_q <= LEG_DEAD;
          tgt_q   <= target;
          cnt_q   <= '0;
        end
        LEG_DEAD: begin
          if (target != tgt_q) begin
            tgt_q <= target;
            cnt_q <= '0;
          end else if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
            state_q <= target ? LEG_ON_HI : LEG_ON_LO;
            hi_q    <= target;
            lo_q    <= ~target;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LEG_ON_HI: begin
          if (!target) begin
            state_q <= LEG_DEAD;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
          end
        end
        LEG_ON_LO: begin
          if (target) begin
            state_q <= LEG_DEAD;
            tgt_q   <= 1'b1;
            cnt_q   <= '0;
            lo_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= LEG_OFF;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/gate_cmd_apply.sv
// Decodes link bytes into enable/pattern commands, applies the pending pattern
// on each synchronized shoot edge and guards the outputs with a watchdog.
module gate_cmd_apply
  import gate_cmd_apply_pkg::*;
#(
  parameter int NUM_LEGS    = 3,
  parameter int DEAD_CYCLES = 48,
  parameter int WDOG_CYCLES = 48000
) (
  input  logic                clk,
  input  logic                reset,
  gate_cmd_apply_if.slave     rx,
  input  logic                shoot_in,
  output logic [NUM_LEGS-1:0] gate_hi,
  output logic [NUM_LEGS-1:0] gate_lo,
  output logic                enabled,
  output logic                pending_valid,
  output logic                wdog_fault,
  output logic [7:0]          err_count
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [1:0]          shoot_sync_q;
  logic                shoot_prev_q;
  logic                enabled_q,  enabled_d;
  logic                fault_q,    fault_d;
  logic                pend_vld_q, pend_vld_d;
  logic                applied_q,  applied_d;
  logic [NUM_LEGS-1:0] pend_q,     pend_d;
  logic [NUM_LEGS-1:0] active_q,   active_d;
  logic [WW-1:0]       wdog_q,     wdog_d;
  logic [7:0]          err_q,      err_d;
  logic                shoot_edge;
  byte_kind_e          byte_kind;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_kind  = classify_byte(rx.rx_done, rx.parity_error, rx.rx_data);
    shoot_edge = shoot_sync_q[1] & ~shoot_prev_q;
    enabled_d  = enabled_q;
    fault_d    = fault_q;
    pend_vld_d = pend_vld_q;
    applied_d  = applied_q;
    pend_d     = pend_q;
    active_d   = active_q;
    err_d      = err_q;
    wdog_d     = (!enabled_q || shoot_edge) ? '0 : wdog_q + WW'(1);

    if (shoot_edge && enabled_q && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      applied_d  = 1'b1;
    end
    // A pattern byte landing with the edge becomes the next pending pattern.
    if (byte_kind == BYTE_PATTERN) begin
      pend_d     = rx.rx_data[NUM_LEGS-1:0];
      pend_vld_d = 1'b1;
    end
    if (byte_kind == BYTE_REJECT && err_q != 8'hFF) err_d = err_q + 8'd1;

    if (enabled_q && !shoot_edge && wdog_q == WW'(WDOG_CYCLES - 1)) begin
      fault_d   = 1'b1;
      enabled_d = 1'b0;
    end
    if (byte_kind == BYTE_DISABLE) enabled_d = 1'b0;
    if (byte_kind == BYTE_ENABLE) begin
      enabled_d = 1'b1;
      fault_d   = 1'b0;
      wdog_d    = '0;
    end
    if (!enabled_d) applied_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shoot_sync_q <= '0;
      shoot_prev_q <= 1'b0;
      enabled_q    <= 1'b0;
      fault_q      <= 1'b0;
      pend_vld_q   <= 1'b0;
      applied_q    <= 1'b0;
      pend_q       <= '0;
      active_q     <= '0;
      wdog_q       <= '0;
      err_q        <= '0;
    end else begin
      shoot_sync_q <= {shoot_sync_q[0], shoot_in};
      shoot_prev_q <= shoot_sync_q[1];
      enabled_q    <= enabled_d;
      fault_q      <= fault_d;
      pend_vld_q   <= pend_vld_d;
      applied_q    <= applied_d;
      pend_q       <= pend_d;
      active_q     <= active_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
    end
  end

  // Legs follow next-state enable so a disable or fault drops gates on the same edge.
  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
    dead_time_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg (
      .clk    (clk),
      .reset  (reset),
      .en     (enabled_d & applied_d),
      .target (active_d[g]),
      .hi     (gate_hi[g]),
      .lo     (gate_lo[g])
    );
  end

  assign enabled       = enabled_q;
  assign pending_valid = pend_vld_q;
  assign wdog_fault    = fault_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_gate_cmd_apply.sv
// Directed and randomized bench for gate_cmd_apply against an event-level
// model, with a per-cycle monitor for gate overlap and dead time.
module tb_gate_cmd_apply;

  localparam int NL = 3;
  localparam int DC = 48;
  localparam int WC = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          shoot_in;
  logic [NL-1:0] gate_hi, gate_lo;
  logic          enabled, pending_valid, wdog_fault;
  logic [7:0]    err_count;

  gate_cmd_apply_if rx_if ();

  gate_cmd_apply #(.NUM_LEGS(NL), .DEAD_CYCLES(DC), .WDOG_CYCLES(WC)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx_if),
    .shoot_in      (shoot_in),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .enabled       (enabled),
    .pending_valid (pending_valid),
    .wdog_fault    (wdog_fault),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event-level reference model.
  bit          m_en, m_pv, m_applied, m_fault;
  bit [NL-1:0] m_pend, m_act;
  int          m_err;

  task automatic model_reset();
    m_en = 0; m_pv = 0; m_applied = 0; m_fault = 0;
    m_pend = '0; m_act = '0; m_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic perr);
    if (perr || (b[7] && b != 8'h80 && b != 8'h81)) begin
      if (m_err < 255) m_err++;
    end else if (!b[7]) begin
      m_pend = b[NL-1:0];
      m_pv   = 1;
    end else if (b == 8'h80) begin
      m_en = 0; m_applied = 0;
    end else begin
      m_en = 1; m_fault = 0;
    end
  endtask

  task automatic model_edge();
    if (m_en && m_pv) begin
      m_act = m_pend; m_pv = 0; m_applied = 1;
    end
  endtask

  function automatic logic [10:0] exp_status();
    return {m_en, m_pv, m_fault, 8'(m_err)};
  endfunction

  function automatic logic [NL-1:0] exp_hi();
    return (m_en && m_applied) ? m_act : '0;
  endfunction

  function automatic logic [NL-1:0] exp_lo();
    return (m_en && m_applied) ? ~m_act : '0;
  endfunction

  // Stimulus drivers: inputs change just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; shoot_in = 0; rx_if.rx_done = 0; rx_if.parity_error = 0;
    idle(2);
    reset = 0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] b, input logic perr);
    @(negedge clk);
    rx_if.rx_data = b; rx_if.rx_done = 1; rx_if.parity_error = perr;
    @(negedge clk);
    rx_if.rx_done = 0; rx_if.parity_error = 0;
    model_byte(b, perr);
  endtask

  task automatic shoot();
    @(negedge clk);
    shoot_in = 1;
    idle(3);
    shoot_in = 0;
    model_edge();
  endtask

  // Overlap and dead-time monitor.
  logic [NL-1:0] prev_hi = '0, prev_lo = '0;
  int            off_run [NL];

  initial for (int i = 0; i < NL; i++) off_run[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      n_checks++;
      if ((gate_hi[i] & gate_lo[i]) === 1'b1) begin
        n_errors++;
        $display("FAIL overlap leg%0d: hi=%b lo=%b required not both 1", i, gate_hi[i], gate_lo[i]);
      end
      if ((gate_hi[i] | gate_lo[i]) === 1'b1 &&
          (gate_hi[i] !== prev_hi[i] || gate_lo[i] !== prev_lo[i])) begin
        n_checks++;
        if (off_run[i] < DC) begin
          n_errors++;
          $display("FAIL dead_time leg%0d: off cycles %0d required >= %0d", i, off_run[i], DC);
        end
      end
      off_run[i] = ((gate_hi[i] | gate_lo[i]) === 1'b1) ? 0 : off_run[i] + 1;
      prev_hi[i] = gate_hi[i];
      prev_lo[i] = gate_lo[i];
    end
  end

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({gate_hi, gate_lo} !== '0) begin
      n_errors++;
      $display("FAIL reset_gates: got hi=%b lo=%b required 0", gate_hi, gate_lo);
    end
    n_checks++;
    if ({enabled, pending_valid, wdog_fault, err_count} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_status: got %h required 0", {enabled, pending_valid, wdog_fault, err_count});
    end
  endtask

  task automatic test_apply_pattern();
    do_reset();
    send(8'h81, 0);
    send(8'h05, 0);
    n_checks++;
    if ({enabled, pending_valid, wdog_fault, err_count} !== exp_status()) begin
      n_errors++;
      $display("FAIL apply_armed: got %h required %h", {enabled, pending_valid, wdog_fault, err_count}, exp_status());
    end
    shoot();
    idle(DC - 1);
    n_checks++;
    if ({gate_hi, gate_lo} !== '0) begin
      n_errors++;
      $display("FAIL apply_dead: got hi=%b lo=%b required 0", gate_hi, gate_lo);
    end
    idle(1);
    n_checks++;
    if (gate_hi !== 3'b101 || gate_lo !== 3'b010 || pending_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL apply_on: got hi=%b lo=%b pv=%b required hi=101 lo=010 pv=0", gate_hi, gate_lo, pending_valid);
    end
  endtask

  task automatic test_dead_restart();
    do_reset();
    send(8'h81, 0);
    send(8'h01, 0);
    shoot();
    idle(DC + 2);
    n_checks++;
    if (gate_hi !== 3'b001 || gate_lo !== 3'b110) begin
      n_errors++;
      $display("FAIL restart_start: got hi=%b lo=%b required hi=001 lo=110", gate_hi, gate_lo);
    end
    send(8'h00, 0);
    shoot();
    n_checks++;
    if (gate_hi !== 3'b000 || gate_lo !== 3'b110) begin
      n_errors++;
      $display("FAIL restart_enter_dead: got hi=%b lo=%b required hi=000 lo=110", gate_hi, gate_lo);
    end
    idle(18);
    send(8'h01, 0);
    shoot();
    idle(DC - 1);
    n_checks++;
    if (gate_hi !== 3'b000 || gate_lo !== 3'b110) begin
      n_errors++;
      $display("FAIL restart_still_dead: got hi=%b lo=%b required hi=000 lo=110", gate_hi, gate_lo);
    end
    idle(1);
    n_checks++;
    if (gate_hi !== 3'b001 || gate_lo !== 3'b110) begin
      n_errors++;
      $display("FAIL restart_on: got hi=%b lo=%b required hi=001 lo=110", gate_hi, gate_lo);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    send(8'h81, 0);
    send(8'h07, 0);
    shoot();
    idle(WC - 1);
    n_checks++;
    if (wdog_fault !== 1'b0 || gate_hi !== 3'b111 || gate_lo !== 3'b000) begin
      n_errors++;
      $display("FAIL wdog_early: got fault=%b hi=%b lo=%b required fault=0 hi=111 lo=000", wdog_fault, gate_hi, gate_lo);
    end
    idle(1);
    m_fault = 1; m_en = 0; m_applied = 0;
    n_checks++;
    if ({enabled, pending_valid, wdog_fault, err_count} !== exp_status() || {gate_hi, gate_lo} !== '0) begin
      n_errors++;
      $display("FAIL wdog_fire: got st=%h hi=%b lo=%b required st=%h gates 0",
               {enabled, pending_valid, wdog_fault, err_count}, gate_hi, gate_lo, exp_status());
    end
    send(8'h81, 0);
    idle(100);
    n_checks++;
    if (wdog_fault !== 1'b0 || enabled !== 1'b1 || {gate_hi, gate_lo} !== '0) begin
      n_errors++;
      $display("FAIL wdog_reenable: got fault=%b en=%b hi=%b lo=%b required 0 1 0 0", wdog_fault, enabled, gate_hi, gate_lo);
    end
    shoot();
    idle(DC + 4);
    n_checks++;
    if ({gate_hi, gate_lo} !== '0) begin
      n_errors++;
      $display("FAIL wdog_empty_shoot: got hi=%b lo=%b required 0", gate_hi, gate_lo);
    end
    send(8'h06, 0);
    shoot();
    idle(DC + 2);
    n_checks++;
    if (gate_hi !== 3'b110 || gate_lo !== 3'b001) begin
      n_errors++;
      $display("FAIL wdog_resume: got hi=%b lo=%b required hi=110 lo=001", gate_hi, gate_lo);
    end
  endtask

  task automatic test_err_count();
    do_reset();
    send(8'h07, 1);
    n_checks++;
    if (err_count !== 8'd1 || pending_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL err_parity: got err=%0d pv=%b required err=1 pv=0", err_count, pending_valid);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) send(8'($urandom_range(0, 255)), 1);
      else                           send(8'(8'h82 + $urandom_range(0, 125)), 0);
    end
    n_checks++;
    if (err_count !== 8'd255 || {enabled, pending_valid, wdog_fault, err_count} !== exp_status()) begin
      n_errors++;
      $display("FAIL err_saturate: got err=%0d st=%h required err=255 st=%h",
               err_count, {enabled, pending_valid, wdog_fault, err_count}, exp_status());
    end
    send(8'h03, 0);
    n_checks++;
    if (err_count !== 8'd255 || pending_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL err_good_byte: got err=%0d pv=%b required err=255 pv=1", err_count, pending_valid);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    send(8'h81, 0);
    send(8'h04, 0);
    @(negedge clk);
    shoot_in = 1;
    idle(2);
    rx_if.rx_data = 8'h02; rx_if.rx_done = 1; rx_if.parity_error = 0;
    idle(1);
    rx_if.rx_done = 0; shoot_in = 0;
    model_edge();
    model_byte(8'h02, 0);
    n_checks++;
    if (pending_valid !== 1'b1 || {enabled, pending_valid, wdog_fault, err_count} !== exp_status()) begin
      n_errors++;
      $display("FAIL same_cycle_pending: got pv=%b st=%h required pv=1 st=%h",
               pending_valid, {enabled, pending_valid, wdog_fault, err_count}, exp_status());
    end
    idle(DC + 2);
    n_checks++;
    if (gate_hi !== 3'b100 || gate_lo !== 3'b011) begin
      n_errors++;
      $display("FAIL same_cycle_active: got hi=%b lo=%b required hi=100 lo=011", gate_hi, gate_lo);
    end
    idle(3);
    shoot();
    idle(DC + 2);
    n_checks++;
    if (gate_hi !== 3'b010 || gate_lo !== 3'b101) begin
      n_errors++;
      $display("FAIL same_cycle_next: got hi=%b lo=%b required hi=010 lo=101", gate_hi, gate_lo);
    end
  endtask

  task automatic test_random();
    int since_shoot = 0;
    do_reset();
    for (int op = 0; op < 400; op++) begin
      int sel = $urandom_range(0, 29);
      if (since_shoot >= 6) sel = 4;
      if (sel <= 3) begin
        int r = $urandom_range(0, 9);
        if (r <= 3)      send(8'($urandom_range(0, 127)), 0);
        else if (r <= 5) send(8'h81, 0);
        else if (r == 6) send(8'h80, 0);
        else if (r == 7) send(8'(8'h82 + $urandom_range(0, 125)), 0);
        else             send(8'($urandom_range(0, 255)), 1);
        since_shoot++;
      end else if (sel <= 6) begin
        shoot();
        idle(3);
        since_shoot = 0;
      end else if (sel <= 14) begin
        idle($urandom_range(0, 40));
        since_shoot++;
      end else if (sel <= 28) begin
        idle(DC + 4);
        n_checks++;
        if (gate_hi !== exp_hi() || gate_lo !== exp_lo()) begin
          n_errors++;
          $display("FAIL rand_gates op%0d: got hi=%b lo=%b required hi=%b lo=%b", op, gate_hi, gate_lo, exp_hi(), exp_lo());
        end
        since_shoot++;
      end else begin
        @(negedge clk);
        #2 reset = 1;
        #1;
        n_checks++;
        if ({gate_hi, gate_lo} !== '0) begin
          n_errors++;
          $display("FAIL rand_async_reset op%0d: got hi=%b lo=%b required 0", op, gate_hi, gate_lo);
        end
        idle(2);
        reset = 0;
        model_reset();
        since_shoot = 0;
      end
      n_checks++;
      if ({enabled, pending_valid, wdog_fault, err_count} !== exp_status() ||
          (!m_en && {gate_hi, gate_lo} !== '0)) begin
        n_errors++;
        $display("FAIL rand_status op%0d: got st=%h hi=%b lo=%b required st=%h",
                 op, {enabled, pending_valid, wdog_fault, err_count}, gate_hi, gate_lo, exp_status());
      end
    end
  endtask

  initial begin
    reset = 1; shoot_in = 0;
    rx_if.rx_data = '0; rx_if.rx_done = 0; rx_if.parity_error = 0;
    model_reset();
    test_reset();
    test_apply_pattern();
    test_dead_restart();
    test_watchdog();
    test_err_count();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
